// File: rtl/tut_nios_sys_pll_reset_seq.sv
`default_nettype none
// ============================================================================
// Module   : tut_nios_sys_pll_reset_seq
// Function : SDRAM PLL lock supervisor and reset sequencer. Pulses the PLL
//            reset, qualifies the synchronized lock flag, releases the system
//            reset and times the SDRAM power-up delay. Optional macro
//            PLL_RETRY_EN re-pulses the PLL after a WAIT_LOCK timeout.
// Revision : 1.0 - initial release
// ============================================================================
module tut_nios_sys_pll_reset_seq #(
    parameter int SYNC_STAGES        = 2,
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int SDRAM_INIT_CYCLES  = 5000,
    parameter int RETRY_TIMEOUT      = 65535,
    parameter int LOSS_CNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pll_locked,
    output logic                  pll_rst,
    output logic                  reset_out,
    output logic                  sdram_init_done,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
    output logic [1:0]            seq_state
);

    localparam logic [1:0] c_ST_PLL_RST   = 2'd0;
    localparam logic [1:0] c_ST_WAIT_LOCK = 2'd1;
    localparam logic [1:0] c_ST_STABLE    = 2'd2;
    localparam logic [1:0] c_ST_RUN       = 2'd3;

    localparam int c_RST_W  = $clog2(PLL_RST_CYCLES) + 1;
    localparam int c_STAB_W = $clog2(LOCK_STABLE_CYCLES) + 1;
    localparam int c_INIT_W = $clog2(SDRAM_INIT_CYCLES) + 1;

    localparam logic [c_RST_W-1:0]  c_RST_LAST  = c_RST_W'(PLL_RST_CYCLES - 1);
    localparam logic [c_STAB_W-1:0] c_STAB_LAST = c_STAB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_INIT_W-1:0] c_INIT_LAST = c_INIT_W'(SDRAM_INIT_CYCLES - 1);
    localparam logic [c_INIT_W-1:0] c_INIT_MAX  = c_INIT_W'(SDRAM_INIT_CYCLES);

`ifdef PLL_RETRY_EN
    localparam int c_RETRY_W = $clog2(RETRY_TIMEOUT) + 1;
    localparam logic [c_RETRY_W-1:0] c_RETRY_LAST = c_RETRY_W'(RETRY_TIMEOUT - 1);
    logic [c_RETRY_W-1:0] r_retry_cnt;
`endif

    logic [SYNC_STAGES-1:0] r_sync;
    logic [1:0]             r_state;
    logic                   r_pll_rst;
    logic                   r_reset_out;
    logic                   r_init_done;
    logic [LOSS_CNT_W-1:0]  r_loss_cnt;
    logic [c_RST_W-1:0]     r_rst_cnt;
    logic [c_STAB_W-1:0]    r_stab_cnt;
    logic [c_INIT_W-1:0]    r_init_cnt;
    logic                   w_lk;

    // Only the last synchronizer stage is trusted by the sequencer.
    assign w_lk = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync      <= '0;
            r_state     <= c_ST_PLL_RST;
            r_pll_rst   <= 1'b1;
            r_reset_out <= 1'b1;
            r_init_done <= 1'b0;
            r_loss_cnt  <= '0;
            r_rst_cnt   <= '0;
            r_stab_cnt  <= '0;
            r_init_cnt  <= '0;
`ifdef PLL_RETRY_EN
            r_retry_cnt <= '0;
`endif
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
            case (r_state)
                c_ST_PLL_RST: begin
                    if (r_rst_cnt == c_RST_LAST) begin
                        r_rst_cnt <= '0;
                        r_state   <= c_ST_WAIT_LOCK;
                        r_pll_rst <= 1'b0;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                    end
                end
                c_ST_WAIT_LOCK: begin
                    if (w_lk) begin
                        r_state    <= c_ST_STABLE;
                        r_stab_cnt <= '0;
`ifdef PLL_RETRY_EN
                        r_retry_cnt <= '0;
                    end else if (r_retry_cnt == c_RETRY_LAST) begin
                        r_retry_cnt <= '0;
                        r_rst_cnt   <= '0;
                        r_state     <= c_ST_PLL_RST;
                        r_pll_rst   <= 1'b1;
                    end else begin
                        r_retry_cnt <= r_retry_cnt + 1'b1;
`endif
                    end
                end
                c_ST_STABLE: begin
                    // A drop on the final qualifying cycle still aborts the release.
                    if (!w_lk) begin
                        r_state    <= c_ST_WAIT_LOCK;
                        r_stab_cnt <= '0;
                    end else if (r_stab_cnt == c_STAB_LAST) begin
                        r_stab_cnt  <= '0;
                        r_init_cnt  <= '0;
                        r_state     <= c_ST_RUN;
                        r_reset_out <= 1'b0;
                    end else begin
                        r_stab_cnt <= r_stab_cnt + 1'b1;
                    end
                end
                c_ST_RUN: begin
                    if (!w_lk) begin
                        r_state     <= c_ST_PLL_RST;
                        r_pll_rst   <= 1'b1;
                        r_reset_out <= 1'b1;
                        r_init_done <= 1'b0;
                        r_init_cnt  <= '0;
                        r_rst_cnt   <= '0;
                        if (!(&r_loss_cnt)) begin
                            r_loss_cnt <= r_loss_cnt + 1'b1;
                        end
                    end else if (r_init_cnt != c_INIT_MAX) begin
                        r_init_cnt <= r_init_cnt + 1'b1;
                        if (r_init_cnt == c_INIT_LAST) begin
                            r_init_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= c_ST_PLL_RST;
                    r_pll_rst   <= 1'b1;
                    r_reset_out <= 1'b1;
                    r_init_done <= 1'b0;
                    r_rst_cnt   <= '0;
                end
            endcase
        end
    end

    assign pll_rst         = r_pll_rst;
    assign reset_out       = r_reset_out;
    assign sdram_init_done = r_init_done;
    assign lock_loss_cnt   = r_loss_cnt;
    assign seq_state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_tut_nios_sys_pll_reset_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_tut_nios_sys_pll_reset_seq
// Function : Directed plus randomized bench for the PLL reset sequencer,
//            checked cycle by cycle against a phase/elapsed-time model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tut_nios_sys_pll_reset_seq;

    localparam int c_SYNC = 2;
    localparam int c_PRC  = 4;
    localparam int c_LSC  = 8;
    localparam int c_SIC  = 10;
    localparam int c_RTO  = 50;
    localparam int c_LW   = 8;
`ifdef PLL_RETRY_EN
    localparam bit c_RETRY = 1'b1;
`else
    localparam bit c_RETRY = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic            pll_locked;
    logic            pll_rst;
    logic            reset_out;
    logic            sdram_init_done;
    logic [c_LW-1:0] lock_loss_cnt;
    logic [1:0]      seq_state;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: phase index, cycles already spent in the phase, loss events, lock delay line.
    int m_phase;
    int m_n;
    int m_loss;
    bit m_s0;
    bit m_s1;
    int cyc;

    tut_nios_sys_pll_reset_seq #(
        .SYNC_STAGES        (c_SYNC),
        .PLL_RST_CYCLES     (c_PRC),
        .LOCK_STABLE_CYCLES (c_LSC),
        .SDRAM_INIT_CYCLES  (c_SIC),
        .RETRY_TIMEOUT      (c_RTO),
        .LOSS_CNT_W         (c_LW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pll_locked      (pll_locked),
        .pll_rst         (pll_rst),
        .reset_out       (reset_out),
        .sdram_init_done (sdram_init_done),
        .lock_loss_cnt   (lock_loss_cnt),
        .seq_state       (seq_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        m_phase = 0;
        m_n     = 0;
        m_loss  = 0;
        m_s0    = 1'b0;
        m_s1    = 1'b0;
    endfunction

    function automatic void model_edge();
        bit lk;
        lk   = m_s1;
        m_s1 = m_s0;
        m_s0 = pll_locked;
        case (m_phase)
            0: if (m_n + 1 == c_PRC) begin m_phase = 1; m_n = 0; end else m_n++;
            1: if (lk) begin m_phase = 2; m_n = 0; end
               else if (c_RETRY && (m_n + 1 == c_RTO)) begin m_phase = 0; m_n = 0; end
               else m_n++;
            2: if (!lk) begin m_phase = 1; m_n = 0; end
               else if (m_n + 1 == c_LSC) begin m_phase = 3; m_n = 0; end
               else m_n++;
            default: if (!lk) begin
                         m_phase = 0;
                         m_n     = 0;
                         if (m_loss < (1 << c_LW) - 1) m_loss++;
                     end else m_n++;
        endcase
    endfunction

    task automatic check_all();
        check("seq_state", 32'(seq_state), 32'(m_phase));
        check("pll_rst", 32'(pll_rst), 32'(m_phase == 0));
        check("reset_out", 32'(reset_out), 32'(m_phase != 3));
        check("sdram_init_done", 32'(sdram_init_done), 32'((m_phase == 3) && (m_n >= c_SIC)));
        check("lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_loss));
    endtask

    task automatic tick(input bit pl);
        pll_locked = pl;
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check_all();
    endtask

    task automatic drop_once();
        tick(1'b0);
        tick(1'b1);
        tick(1'b1);
    endtask

    task automatic run_until_run();
        int k;
        k = 0;
        while (m_phase != 3 && k < 200) begin
            tick(1'b1);
            k++;
        end
        check("reach_run", 32'(seq_state), 32'd3);
    endtask

    initial begin
        int t_rel, t_done, n_prst, g, k, nr, len;
        bit prev, lvl;
        rst        = 1'b1;
        pll_locked = 1'b0;
        cyc        = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        #4 rst = 1'b0;
        check_all();

        // Clean startup: lock raised in cycle 10.
        t_rel  = -1;
        t_done = -1;
        n_prst = pll_rst ? 1 : 0;
        while (cyc < 40) begin
            tick(cyc >= 10);
            if (pll_rst) n_prst++;
            if (t_rel < 0 && !reset_out) t_rel = cyc;
            if (t_done < 0 && sdram_init_done) t_done = cyc;
        end
        check("startup_pll_rst_cycles", 32'(n_prst), 32'd4);
        check("startup_release_cycle", 32'(t_rel), 32'd21);
        check("startup_done_cycle", 32'(t_done), 32'd31);
        check("startup_loss_cnt", 32'(lock_loss_cnt), 32'd0);

        // Single-cycle lock drop while running.
        drop_once();
        check("loss_reset_out", 32'(reset_out), 32'd1);
        check("loss_pll_rst", 32'(pll_rst), 32'd1);
        check("loss_done_low", 32'(sdram_init_done), 32'd0);
        check("loss_cnt_one", 32'(lock_loss_cnt), 32'd1);
        run_until_run();

        // Glitch lands on the last STABLE cycle after the synchronizer delay.
        drop_once();
        k = 0;
        while (!(m_phase == 2 && m_n == 5) && k < 200) begin tick(1'b1); k++; end
        g = cyc;
        tick(1'b0);
        k = 0;
        while (reset_out !== 1'b0 && k < 200) begin tick(1'b1); k++; end
        check("glitch_release_gap", 32'(cyc - g), 32'd12);
        check("glitch_no_loss", 32'(lock_loss_cnt), 32'd2);

        // Lock held low: PLL reset re-pulses only with the retry feature.
        repeat (c_SIC + 2) tick(1'b1);
        nr   = 0;
        prev = pll_rst;
        repeat (200) begin
            tick(1'b0);
            if (pll_rst && !prev) nr++;
            prev = pll_rst;
        end
`ifdef PLL_RETRY_EN
        check("retry_pulses", 32'(nr), 32'd4);
`else
        check("no_retry_pulses", 32'(nr), 32'd1);
`endif

        // Saturation of the loss counter.
        for (int i = 0; i < 300; i++) begin
            run_until_run();
            drop_once();
        end
        check("loss_saturated", 32'(lock_loss_cnt), 32'd255);

        // Asynchronous reset while running with init done.
        run_until_run();
        repeat (c_SIC + 2) tick(1'b1);
        check("pre_rst_done", 32'(sdram_init_done), 32'd1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        check("async_reset_out", 32'(reset_out), 32'd1);
        #3 rst = 1'b0;

        // Randomized lock behaviour.
        repeat (60) begin
            lvl = ($urandom_range(0, 2) != 0);
            len = $urandom_range(1, 40);
            repeat (len) tick(lvl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
